// File: rtl/multiport_sgmii_lane_bridge.sv
// multiport_sgmii_lane_bridge
//
// Bridges an N-port interleaved SERDES symbol stream (NUM_PORTS decoded bytes
// per clock) to per-port SGMII byte lanes, and back again on the TX side.
// The port-0 byte position is not fixed. A hunt/confirm/locked state machine
// finds it by looking for the port-0 K28.1 comma. The RX word is then
// de-rotated across the previous and current valid words, so that lane k
// carries port k.
//
// Optional feature: define MULTIPORT_SGMII_STATS_EN to build the 16-bit
// saturating lock-loss and per-lane error counters. When it is undefined, both
// stat outputs are tied to zero.
//
// Ports
//   clk, rst_n                   single 125 MHz clock, synchronous active-low reset
//   rx_data_valid                input word valid
//   rx_data / rx_data_is_ctl     interleaved bytes (byte i at [i*8 +: 8]) + K flags
//   rx_disparity_err/symbol_err  per-byte error flags
//   sgmii_rx_*                   de-rotated lanes, lane k = port k, plus valid
//   rx_aligned / rx_rotation     lock status and locked port-0 byte position
//   sgmii_tx_*                   per-port TX lanes in
//   tx_*                         interleaved TX stream out, port-0 K28.5 -> K28.1
//   stat_lock_loss, stat_rx_err  statistics (MULTIPORT_SGMII_STATS_EN only)
module multiport_sgmii_lane_bridge #(
  parameter int NUM_PORTS  = 4,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rx_data_valid,
  input  logic [NUM_PORTS*8-1:0]       rx_data,
  input  logic [NUM_PORTS-1:0]         rx_data_is_ctl,
  input  logic [NUM_PORTS-1:0]         rx_disparity_err,
  input  logic [NUM_PORTS-1:0]         rx_symbol_err,
  output logic                         sgmii_rx_data_valid,
  output logic [NUM_PORTS*8-1:0]       sgmii_rx_data,
  output logic [NUM_PORTS-1:0]         sgmii_rx_data_is_ctl,
  output logic [NUM_PORTS-1:0]         sgmii_rx_disparity_err,
  output logic [NUM_PORTS-1:0]         sgmii_rx_symbol_err,
  output logic                         rx_aligned,
  output logic [$clog2(NUM_PORTS)-1:0] rx_rotation,
  input  logic [NUM_PORTS*8-1:0]       sgmii_tx_data,
  input  logic [NUM_PORTS-1:0]         sgmii_tx_data_is_ctl,
  input  logic [NUM_PORTS-1:0]         sgmii_tx_force_disparity_negative,
  output logic [NUM_PORTS*8-1:0]       tx_data,
  output logic [NUM_PORTS-1:0]         tx_data_is_ctl,
  output logic [NUM_PORTS-1:0]         tx_force_disparity_negative,
  output logic [15:0]                  stat_lock_loss,
  output logic [NUM_PORTS*16-1:0]      stat_rx_err
);

  localparam int RW = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_t;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  state_t          state_q, state_d;
  logic [RW-1:0]   cand_q, cand_d, rot_q, rot_d;
  logic [3:0]      cnt_q, cnt_d, miss_q, miss_d;
  logic            loss_evt;

  logic [NUM_PORTS-1:0] hit, k285, ref_mask;
  logic                 hit_any, hit_multi, hit_ref, miss_ref;
  logic [RW-1:0]        hit_pos, ref_pos;

  // Comma classification of the incoming word
  always_comb begin
    hit       = '0;
    k285      = '0;
    hit_any   = 1'b0;
    hit_multi = 1'b0;
    hit_pos   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      hit[i]  = rx_data_valid && rx_data_is_ctl[i] && (rx_data[i*8 +: 8] == 8'h3C);
      k285[i] = rx_data_valid && rx_data_is_ctl[i] && (rx_data[i*8 +: 8] == 8'hBC);
      if (hit[i]) begin
        hit_multi = hit_multi | hit_any;
        hit_any   = 1'b1;
        hit_pos   = RW'(i);
      end
    end
    // Candidate position while confirming, locked position once locked.
    ref_pos           = (state_q == LOCKED) ? rot_q : cand_q;
    ref_mask          = '0;
    ref_mask[ref_pos] = 1'b1;
    hit_ref           = hit[ref_pos];
    miss_ref          = k285[ref_pos] || ((hit & ~ref_mask) != '0);
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    rot_d    = rot_q;
    cnt_d    = cnt_q;
    miss_d   = miss_q;
    loss_evt = 1'b0;
    if (rx_data_valid) begin
      case (state_q)
        HUNT: begin
          if (hit_any && !hit_multi) begin
            cand_d = hit_pos;
            cnt_d  = 4'd1;
            if (LOCK_COUNT == 1) begin
              rot_d   = hit_pos;
              miss_d  = '0;
              state_d = LOCKED;
            end else begin
              state_d = CONFIRM;
            end
          end
        end
        CONFIRM: begin
          if (miss_ref) begin
            cnt_d   = '0;
            state_d = HUNT;
          end else if (hit_ref) begin
            cnt_d = sat_inc4(cnt_q);
            if (sat_inc4(cnt_q) >= 4'(LOCK_COUNT)) begin
              rot_d   = cand_q;
              miss_d  = '0;
              state_d = LOCKED;
            end
          end
        end
        LOCKED: begin
          // A miss anywhere dominates a simultaneous hit at the rotation.
          if (miss_ref) begin
            if (sat_inc4(miss_q) >= 4'(LOSS_COUNT)) begin
              state_d  = HUNT;
              cnt_d    = '0;
              miss_d   = '0;
              loss_evt = 1'b1;
            end else begin
              miss_d = sat_inc4(miss_q);
            end
          end else if (hit_ref) begin
            miss_d = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HUNT;
      cand_q  <= '0;
      rot_q   <= '0;
      cnt_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      rot_q   <= rot_d;
      cnt_q   <= cnt_d;
      miss_q  <= miss_d;
    end
  end

  assign rx_aligned  = (state_q == LOCKED);
  assign rx_rotation = rot_q;

  // p0: previous valid word, held across invalid cycles
  logic [NUM_PORTS*8-1:0] prev_data_p0;
  logic [NUM_PORTS-1:0]   prev_ctl_p0, prev_de_p0, prev_se_p0;
  logic [NUM_PORTS*8-1:0] derot_data;
  logic [NUM_PORTS-1:0]   derot_ctl, derot_de, derot_se;

  always_comb begin
    derot_data = '0;
    derot_ctl  = '0;
    derot_de   = '0;
    derot_se   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (int'(rot_q) + k < NUM_PORTS) begin
        derot_data[k*8 +: 8] = prev_data_p0[(int'(rot_q) + k)*8 +: 8];
        derot_ctl[k]         = prev_ctl_p0[int'(rot_q) + k];
        derot_de[k]          = prev_de_p0[int'(rot_q) + k];
        derot_se[k]          = prev_se_p0[int'(rot_q) + k];
      end else begin
        derot_data[k*8 +: 8] = rx_data[(int'(rot_q) + k - NUM_PORTS)*8 +: 8];
        derot_ctl[k]         = rx_data_is_ctl[int'(rot_q) + k - NUM_PORTS];
        derot_de[k]          = rx_disparity_err[int'(rot_q) + k - NUM_PORTS];
        derot_se[k]          = rx_symbol_err[int'(rot_q) + k - NUM_PORTS];
      end
    end
  end

  // p1: registered de-rotated lanes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_data_p0           <= '0;
      prev_ctl_p0            <= '0;
      prev_de_p0             <= '0;
      prev_se_p0             <= '0;
      sgmii_rx_data_valid    <= 1'b0;
      sgmii_rx_data          <= '0;
      sgmii_rx_data_is_ctl   <= '0;
      sgmii_rx_disparity_err <= '0;
      sgmii_rx_symbol_err    <= '0;
    end else begin
      sgmii_rx_data_valid <= rx_data_valid && (state_q == LOCKED);
      if (rx_data_valid) begin
        prev_data_p0           <= rx_data;
        prev_ctl_p0            <= rx_data_is_ctl;
        prev_de_p0             <= rx_disparity_err;
        prev_se_p0             <= rx_symbol_err;
        sgmii_rx_data          <= derot_data;
        sgmii_rx_data_is_ctl   <= derot_ctl;
        sgmii_rx_disparity_err <= derot_de;
        sgmii_rx_symbol_err    <= derot_se;
      end
    end
  end

  // p0 (TX): lane k to byte k; the port-0 K28.5 is re-marked as K28.1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_data                     <= '0;
      tx_data_is_ctl              <= '0;
      tx_force_disparity_negative <= '0;
    end else begin
      tx_data                     <= sgmii_tx_data;
      tx_data_is_ctl              <= sgmii_tx_data_is_ctl;
      tx_force_disparity_negative <= sgmii_tx_force_disparity_negative;
      if (sgmii_tx_data_is_ctl[0] && (sgmii_tx_data[7:0] == 8'hBC))
        tx_data[7:0] <= 8'h3C;
    end
  end

`ifdef MULTIPORT_SGMII_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_lock_loss <= '0;
      stat_rx_err    <= '0;
    end else begin
      if (loss_evt)
        stat_lock_loss <= sat_inc16(stat_lock_loss);
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (sgmii_rx_data_valid && (sgmii_rx_disparity_err[k] || sgmii_rx_symbol_err[k]))
          stat_rx_err[k*16 +: 16] <= sat_inc16(stat_rx_err[k*16 +: 16]);
      end
    end
  end
`else
  logic unused_loss_evt;
  assign unused_loss_evt = loss_evt;
  assign stat_lock_loss  = '0;
  assign stat_rx_err     = '0;
`endif

endmodule

// File: tb/tb_multiport_sgmii_lane_bridge.sv
// Directed bench for multiport_sgmii_lane_bridge: a 4-port instance (lock,
// de-rotation, stream continuity, loss, ambiguity, TX) and an 8-port instance
// (rotation 7, reset while locked).
module tb_multiport_sgmii_lane_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

`ifdef MULTIPORT_SGMII_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [31:0] IDLE4 = 32'h5050_5050;
  localparam logic [31:0] K281_B2 = 32'h003C_0000;
  localparam logic [31:0] K285_B2 = 32'h00BC_0000;
  localparam logic [63:0] IDLE8 = 64'h5050_5050_5050_5050;
  localparam logic [63:0] K281_B7 = 64'h3C00_0000_0000_0000;

  // 4-port instance
  logic        rst_n, rx_v4;
  logic [31:0] rx_d4;
  logic [3:0]  rx_c4, rx_de4, rx_se4;
  logic        sg_v4, al4;
  logic [31:0] sg_d4;
  logic [3:0]  sg_c4, sg_de4, sg_se4;
  logic [1:0]  rot4;
  logic [31:0] txi_d4, txo_d4;
  logic [3:0]  txi_c4, txi_f4, txo_c4, txo_f4;
  logic [15:0] sll4;
  logic [63:0] sre4;

  multiport_sgmii_lane_bridge #(.NUM_PORTS(4), .LOCK_COUNT(4), .LOSS_COUNT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .rx_data_valid(rx_v4), .rx_data(rx_d4), .rx_data_is_ctl(rx_c4),
    .rx_disparity_err(rx_de4), .rx_symbol_err(rx_se4),
    .sgmii_rx_data_valid(sg_v4), .sgmii_rx_data(sg_d4), .sgmii_rx_data_is_ctl(sg_c4),
    .sgmii_rx_disparity_err(sg_de4), .sgmii_rx_symbol_err(sg_se4),
    .rx_aligned(al4), .rx_rotation(rot4),
    .sgmii_tx_data(txi_d4), .sgmii_tx_data_is_ctl(txi_c4),
    .sgmii_tx_force_disparity_negative(txi_f4),
    .tx_data(txo_d4), .tx_data_is_ctl(txo_c4), .tx_force_disparity_negative(txo_f4),
    .stat_lock_loss(sll4), .stat_rx_err(sre4)
  );

  // 8-port instance
  logic         rst8_n, rx_v8, sg_v8, al8;
  logic [63:0]  rx_d8, sg_d8, txi_d8, unused_txo_d8;
  logic [7:0]   rx_c8, rx_e8, sg_c8, txi_c8, txi_f8;
  logic [7:0]   unused_de8, unused_se8, unused_txo_c8, unused_txo_f8;
  logic [2:0]   rot8;
  logic [15:0]  sll8;
  logic [127:0] sre8;

  assign rx_e8  = 8'h00;
  assign txi_d8 = 64'h0;
  assign txi_c8 = 8'h00;
  assign txi_f8 = 8'h00;

  multiport_sgmii_lane_bridge #(.NUM_PORTS(8), .LOCK_COUNT(4), .LOSS_COUNT(4)) u_dut8 (
    .clk(clk), .rst_n(rst8_n),
    .rx_data_valid(rx_v8), .rx_data(rx_d8), .rx_data_is_ctl(rx_c8),
    .rx_disparity_err(rx_e8), .rx_symbol_err(rx_e8),
    .sgmii_rx_data_valid(sg_v8), .sgmii_rx_data(sg_d8), .sgmii_rx_data_is_ctl(sg_c8),
    .sgmii_rx_disparity_err(unused_de8), .sgmii_rx_symbol_err(unused_se8),
    .rx_aligned(al8), .rx_rotation(rot8),
    .sgmii_tx_data(txi_d8), .sgmii_tx_data_is_ctl(txi_c8),
    .sgmii_tx_force_disparity_negative(txi_f8),
    .tx_data(unused_txo_d8), .tx_data_is_ctl(unused_txo_c8),
    .tx_force_disparity_negative(unused_txo_f8),
    .stat_lock_loss(sll8), .stat_rx_err(sre8)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc4(input logic v, input logic [31:0] d, input logic [3:0] c,
                      input logic [3:0] de, input logic [3:0] se);
    rx_v4 = v; rx_d4 = d; rx_c4 = c; rx_de4 = de; rx_se4 = se;
    @(posedge clk); #1;
  endtask

  task automatic cyc8(input logic v, input logic [63:0] d, input logic [7:0] c);
    rx_v8 = v; rx_d8 = d; rx_c8 = c;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] w4, e4;

  initial begin
    rst_n = 1'b0; rst8_n = 1'b0;
    rx_v4 = 1'b0; rx_d4 = '0; rx_c4 = '0; rx_de4 = '0; rx_se4 = '0;
    txi_d4 = '0; txi_c4 = '0; txi_f4 = '0;
    rx_v8 = 1'b0; rx_d8 = '0; rx_c8 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_aligned4", 64'(al4), 64'(0));
    check_val("rst_rotation4", 64'(rot4), 64'(0));
    check_val("rst_valid4", 64'(sg_v4), 64'(0));
    check_val("rst_data4", 64'(sg_d4), 64'(0));
    check_val("rst_txdata4", 64'(txo_d4), 64'(0));
    check_val("rst_stat_loss4", 64'(sll4), 64'(0));
    check_val("rst_stat_err4", sre4, 64'(0));
    check_val("rst_aligned8", 64'(al8), 64'(0));
    rst_n = 1'b1; rst8_n = 1'b1;

    // TX: lane 0 K28.5 becomes K28.1, lane 1 K28.5 untouched, one cycle late
    txi_d4 = 32'h1122_BCBC; txi_c4 = 4'b0011; txi_f4 = 4'b1010;
    #1;
    check_val("tx_latency", 64'(txo_d4), 64'(0));
    @(posedge clk); #1;
    check_val("tx_remap_data", 64'(txo_d4), 64'h1122_BC3C);
    check_val("tx_remap_ctl", 64'(txo_c4), 64'(4'b0011));
    check_val("tx_fdn", 64'(txo_f4), 64'(4'b1010));
    txi_c4 = 4'b0010;
    @(posedge clk); #1;
    check_val("tx_lane0_data_bc", 64'(txo_d4), 64'h1122_BCBC);

    // Lock at rotation 2
    for (int i = 0; i < 3; i++) begin
      cyc4(1'b1, K281_B2, 4'b0100, 4'h0, 4'h0);
      cyc4(1'b1, IDLE4, 4'h0, 4'h0, 4'h0);
    end
    check_val("lock_cnt3", 64'(al4), 64'(0));
    cyc4(1'b1, 32'h113C_2233, 4'b0100, 4'h0, 4'b1000);
    check_val("lock_aligned", 64'(al4), 64'(1));
    check_val("lock_rotation", 64'(rot4), 64'(2));
    cyc4(1'b1, 32'h4455_6677, 4'h0, 4'b0001, 4'h0);
    check_val("derot_valid", 64'(sg_v4), 64'(1));
    check_val("derot_data", 64'(sg_d4), 64'h6677_113C);
    check_val("derot_ctl", 64'(sg_c4), 64'(4'b0001));
    check_val("derot_de", 64'(sg_de4), 64'(4'b0100));
    check_val("derot_se", 64'(sg_se4), 64'(4'b0010));
    cyc4(1'b1, IDLE4, 4'h0, 4'h0, 4'h0);
    check_val("stat_rx_err", sre4, STATS ? 64'h0000_0001_0001_0000 : 64'h0);

    // Valid toggling with an incrementing byte stream; invalid words carry commas
    for (int n = 1; n <= 6; n++) begin
      w4 = {8'(4*n+3), 8'(4*n+2), 8'(4*n+1), 8'(4*n)};
      e4 = {8'(4*n+1), 8'(4*n), 8'(4*n-1), 8'(4*n-2)};
      cyc4(1'b1, w4, 4'h0, 4'h0, 4'h0);
      if (n >= 2) begin
        check_val("stream_data", 64'(sg_d4), 64'(e4));
        check_val("stream_valid", 64'(sg_v4), 64'(1));
      end
      cyc4(1'b0, 32'h3C3C_3C3C, 4'hF, 4'h0, 4'h0);
      if (n >= 2) begin
        check_val("hold_data", 64'(sg_d4), 64'(e4));
        check_val("hold_valid", 64'(sg_v4), 64'(0));
      end
    end
    check_val("stream_still_aligned", 64'(al4), 64'(1));

    // Loss of lock: K28.5 at the rotation position
    for (int i = 0; i < 3; i++) begin
      cyc4(1'b1, K285_B2, 4'b0100, 4'h0, 4'h0);
      cyc4(1'b1, IDLE4, 4'h0, 4'h0, 4'h0);
    end
    check_val("loss_miss3", 64'(al4), 64'(1));
    cyc4(1'b1, K285_B2, 4'b0100, 4'h0, 4'h0);
    check_val("loss_aligned", 64'(al4), 64'(0));
    check_val("loss_stat", 64'(sll4), STATS ? 64'(1) : 64'(0));

    // Valid-low cycles hold the confirm count
    cyc4(1'b1, K281_B2, 4'b0100, 4'h0, 4'h0);
    cyc4(1'b1, K281_B2, 4'b0100, 4'h0, 4'h0);
    repeat (3) cyc4(1'b0, K281_B2, 4'b0100, 4'h0, 4'h0);
    check_val("vldlow_no_count", 64'(al4), 64'(0));
    cyc4(1'b1, K281_B2, 4'b0100, 4'h0, 4'h0);
    check_val("vldlow_cnt3", 64'(al4), 64'(0));
    cyc4(1'b1, K281_B2, 4'b0100, 4'h0, 4'h0);
    check_val("vldlow_cnt_held", 64'(al4), 64'(1));
    repeat (4) cyc4(1'b1, K285_B2, 4'b0100, 4'h0, 4'h0);
    check_val("loss2_aligned", 64'(al4), 64'(0));
    check_val("loss2_stat", 64'(sll4), STATS ? 64'(2) : 64'(0));

    // Ambiguous hit in CONFIRM (cnt=2) restarts the hunt
    cyc4(1'b1, K281_B2, 4'b0100, 4'h0, 4'h0);
    cyc4(1'b1, K281_B2, 4'b0100, 4'h0, 4'h0);
    cyc4(1'b1, 32'h003C_003C, 4'b0101, 4'h0, 4'h0);
    repeat (3) cyc4(1'b1, K281_B2, 4'b0100, 4'h0, 4'h0);
    check_val("ambig_restart", 64'(al4), 64'(0));
    cyc4(1'b1, K281_B2, 4'b0100, 4'h0, 4'h0);
    check_val("ambig_relock", 64'(al4), 64'(1));
    check_val("ambig_rotation", 64'(rot4), 64'(2));

    // 8 ports, rotation 7, reset while locked
    repeat (3) begin
      cyc8(1'b1, K281_B7, 8'h80);
      cyc8(1'b1, IDLE8, 8'h00);
    end
    check_val("p8_cnt3", 64'(al8), 64'(0));
    cyc8(1'b1, K281_B7, 8'h80);
    check_val("p8_aligned", 64'(al8), 64'(1));
    check_val("p8_rotation", 64'(rot8), 64'(7));
    cyc8(1'b1, 64'h0123_4567_89AB_CDEF, 8'h00);
    check_val("p8_derot_data", sg_d8, 64'h2345_6789_ABCD_EF3C);
    check_val("p8_derot_ctl", 64'(sg_c8), 64'(8'h01));
    check_val("p8_derot_valid", 64'(sg_v8), 64'(1));
    rst8_n = 1'b0;
    cyc8(1'b0, IDLE8, 8'h00);
    rst8_n = 1'b1;
    check_val("p8_rst_aligned", 64'(al8), 64'(0));
    check_val("p8_rst_rotation", 64'(rot8), 64'(0));
    check_val("p8_rst_valid", 64'(sg_v8), 64'(0));
    check_val("p8_rst_data", sg_d8, 64'(0));
    check_val("p8_rst_ctl", 64'(sg_c8), 64'(0));
    check_val("p8_rst_stats", 64'((sre8 != '0) || (sll8 != '0)), 64'(0));
    repeat (3) cyc8(1'b1, K281_B7, 8'h80);
    check_val("p8_relock_cnt3", 64'(al8), 64'(0));
    cyc8(1'b1, K281_B7, 8'h80);
    check_val("p8_relock", 64'(al8), 64'(1));
    check_val("p8_relock_rotation", 64'(rot8), 64'(7));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
